// File: rtl/avalon_aes_slave.sv
`default_nettype none
// ============================================================================
// Module      : avalon_aes_slave
// Description : Avalon-MM register slave that feeds an AES decrypt core.
//               Software loads key and ciphertext words, sets START, and
//               this block drives the core. When the core finishes, the
//               plaintext is captured and DONE is raised. A watchdog aborts
//               a run if the core never answers.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_aes_slave #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AVL_CS,
  input  logic         AVL_READ,
  input  logic         AVL_WRITE,
  input  logic [3:0]   AVL_ADDR,
  input  logic [3:0]   AVL_BYTE_EN,
  input  logic [31:0]  AVL_WRITEDATA,
  output logic [31:0]  AVL_READDATA,
  output logic         AES_START,
  input  logic         AES_DONE,
  output logic [127:0] AES_KEY,
  output logic [127:0] AES_MSG_ENC,
  input  logic [127:0] AES_MSG_DEC,
  output logic [31:0]  EXPORT_DATA
);

  // Register addresses that have special handling
  localparam logic [3:0]  c_ADDR_START  = 4'd14;
  localparam logic [3:0]  c_ADDR_STATUS = 4'd15;
  // Watchdog is only armed when a nonzero limit is configured
  localparam logic        c_WDOG_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] c_WDOG_LAST   = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [127:0]  key_q;
  logic [127:0]  enc_q;
  logic [127:0]  dec_q;
  logic          start_q, start_d;
  logic          done_q;
  logic          timeout_q;
  logic [31:0]   wdog_q;
  logic [31:0]   rdata_q;

  logic          wr_en;
  logic          rd_en;
  logic          core_wr_ok;
  logic [31:0]   byte_mask;
  logic [31:0]   rd_mux;
  logic          busy;

  // FSM control strobes
  logic          capture;
  logic          set_timeout;
  logic          clr_flags;
  logic          wdog_clr;
  logic          wdog_inc;

  assign wr_en      = AVL_CS & AVL_WRITE;
  assign rd_en      = AVL_CS & AVL_READ;
  // Core inputs are frozen while the core may be consuming them
  assign core_wr_ok = wr_en & (state_q == ST_IDLE);
  assign byte_mask  = {{8{AVL_BYTE_EN[3]}}, {8{AVL_BYTE_EN[2]}},
                       {8{AVL_BYTE_EN[1]}}, {8{AVL_BYTE_EN[0]}}};
  assign busy       = (state_q == ST_RUN);

  assign AES_KEY      = key_q;
  assign AES_MSG_ENC  = enc_q;
  assign AES_START    = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign EXPORT_DATA  = {key_q[127:112], key_q[15:0]};
  assign AVL_READDATA = rdata_q;

  // Value START will hold after this edge; lets the FSM react to the write
  // in the same cycle it lands.
  always_comb begin
    start_d = start_q;
    if (wr_en && (AVL_ADDR == c_ADDR_START) && AVL_BYTE_EN[0]) begin
      start_d = AVL_WRITEDATA[0];
    end
  end

  // Key and ciphertext registers with byte-enable merge; plaintext capture
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      key_q <= '0;
      enc_q <= '0;
      dec_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (core_wr_ok && (AVL_ADDR == 4'(i))) begin
          key_q[127-32*i -: 32] <= (key_q[127-32*i -: 32] & ~byte_mask) |
                                   (AVL_WRITEDATA & byte_mask);
        end
        if (core_wr_ok && (AVL_ADDR == 4'(i + 4))) begin
          enc_q[127-32*i -: 32] <= (enc_q[127-32*i -: 32] & ~byte_mask) |
                                   (AVL_WRITEDATA & byte_mask);
        end
      end
      if (capture) begin
        dec_q <= AES_MSG_DEC;
      end
    end
  end

  // START bit and the sticky DONE / TIMEOUT status flags
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      start_q <= start_d;
      if (clr_flags) begin
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
      end
      if (capture) begin
        done_q <= 1'b1;
      end
      if (set_timeout) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Saturating watchdog counter, restarted on every RUN entry
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wdog_q <= '0;
    end else if (wdog_clr) begin
      wdog_q <= '0;
    end else if (wdog_inc && (wdog_q != 32'hFFFF_FFFF)) begin
      wdog_q <= wdog_q + 32'd1;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and control strobes; core completion beats the watchdog
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    set_timeout = 1'b0;
    clr_flags   = 1'b0;
    wdog_clr    = 1'b0;
    wdog_inc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_d) begin
          state_d   = ST_RUN;
          clr_flags = 1'b1;
          wdog_clr  = 1'b1;
        end
      end
      ST_RUN: begin
        if (AES_DONE) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end else if (c_WDOG_EN && (wdog_q == c_WDOG_LAST)) begin
          set_timeout = 1'b1;
          state_d     = ST_ABORT;
        end else begin
          wdog_inc = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!start_d) begin
          state_d = ST_IDLE;
        end
      end
      ST_ABORT: begin
        if (!start_d) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read mux built from pre-write register values
  always_comb begin
    rd_mux = '0;
    case (AVL_ADDR)
      4'd0:          rd_mux = key_q[127:96];
      4'd1:          rd_mux = key_q[95:64];
      4'd2:          rd_mux = key_q[63:32];
      4'd3:          rd_mux = key_q[31:0];
      4'd4:          rd_mux = enc_q[127:96];
      4'd5:          rd_mux = enc_q[95:64];
      4'd6:          rd_mux = enc_q[63:32];
      4'd7:          rd_mux = enc_q[31:0];
      4'd8:          rd_mux = dec_q[127:96];
      4'd9:          rd_mux = dec_q[95:64];
      4'd10:         rd_mux = dec_q[63:32];
      4'd11:         rd_mux = dec_q[31:0];
      c_ADDR_START:  rd_mux = {31'd0, start_q};
      c_ADDR_STATUS: rd_mux = {29'd0, busy, timeout_q, done_q};
      default:       rd_mux = '0;
    endcase
  end

  // Read data register: one-cycle latency, holds between reads
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= rd_mux;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avalon_aes_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_aes_slave
// Description : Directed self-checking bench for avalon_aes_slave. The bench
//               plays the AES core: it answers with a fixed plaintext or
//               stays silent to trip the watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_aes_slave;

  logic         CLK;
  logic         RESET;
  logic         AVL_CS;
  logic         AVL_READ;
  logic         AVL_WRITE;
  logic [3:0]   AVL_ADDR;
  logic [3:0]   AVL_BYTE_EN;
  logic [31:0]  AVL_WRITEDATA;
  logic [31:0]  AVL_READDATA;
  logic         AES_START;
  logic         AES_DONE;
  logic [127:0] AES_KEY;
  logic [127:0] AES_MSG_ENC;
  logic [127:0] AES_MSG_DEC;
  logic [31:0]  EXPORT_DATA;

  int vectors;
  int miscompares;

  localparam logic [127:0] c_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] c_ENC = 128'hdaec3055df058e1c39e814ea76f6747e;
  localparam logic [127:0] c_DEC = 128'hece298dcece298dcece298dcece298dc;
  localparam logic [127:0] c_DEC2 = 128'h0123456789abcdef0011223344556677;

  avalon_aes_slave #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .AVL_CS       (AVL_CS),
    .AVL_READ     (AVL_READ),
    .AVL_WRITE    (AVL_WRITE),
    .AVL_ADDR     (AVL_ADDR),
    .AVL_BYTE_EN  (AVL_BYTE_EN),
    .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA (AVL_READDATA),
    .AES_START    (AES_START),
    .AES_DONE     (AES_DONE),
    .AES_KEY      (AES_KEY),
    .AES_MSG_ENC  (AES_MSG_ENC),
    .AES_MSG_DEC  (AES_MSG_DEC),
    .EXPORT_DATA  (EXPORT_DATA)
  );

  // 50 MHz clock
  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus ops are called at a falling edge and return at the next falling edge
  task automatic wr(input logic cs, input logic [3:0] addr, input logic [31:0] data,
                    input logic [3:0] be);
    AVL_CS        = cs;
    AVL_WRITE     = 1'b1;
    AVL_ADDR      = addr;
    AVL_WRITEDATA = data;
    AVL_BYTE_EN   = be;
    @(negedge CLK);
    AVL_CS    = 1'b0;
    AVL_WRITE = 1'b0;
  endtask

  task automatic rd(input logic [3:0] addr, output logic [31:0] data);
    AVL_CS   = 1'b1;
    AVL_READ = 1'b1;
    AVL_ADDR = addr;
    @(negedge CLK);
    AVL_CS   = 1'b0;
    AVL_READ = 1'b0;
    data     = AVL_READDATA;
  endtask

  initial begin
    logic [31:0] d;
    vectors       = 0;
    miscompares   = 0;
    RESET         = 1'b1;
    AVL_CS        = 1'b0;
    AVL_READ      = 1'b0;
    AVL_WRITE     = 1'b0;
    AVL_ADDR      = 4'd0;
    AVL_BYTE_EN   = 4'd0;
    AVL_WRITEDATA = 32'd0;
    AES_DONE      = 1'b0;
    AES_MSG_DEC   = '0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;

    // 1: reset state
    check("rst_aes_start", {127'd0, AES_START}, 128'd0);
    check("rst_export", {96'd0, EXPORT_DATA}, 128'd0);
    check("rst_readdata", {96'd0, AVL_READDATA}, 128'd0);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), d);
      check($sformatf("rst_reg%0d", a), {96'd0, d}, 128'd0);
    end

    // 3: byte-enable merge, ignored writes
    wr(1'b1, 4'd0, 32'hAABBCCDD, 4'b0101);
    rd(4'd0, d);
    check("be_reg0", {96'd0, d}, {96'd0, 32'h00BB00DD});
    check("be_export", {96'd0, EXPORT_DATA}, {96'd0, 32'h00BB0000});
    check("be_aes_key", AES_KEY, {32'h00BB00DD, 96'd0});
    repeat (2) @(negedge CLK);
    check("rd_hold", {96'd0, AVL_READDATA}, {96'd0, 32'h00BB00DD});
    wr(1'b0, 4'd1, 32'hFFFFFFFF, 4'hF);
    rd(4'd1, d);
    check("nocs_reg1", {96'd0, d}, 128'd0);
    wr(1'b1, 4'd9, 32'hFFFFFFFF, 4'hF);
    wr(1'b1, 4'd12, 32'hFFFFFFFF, 4'hF);
    wr(1'b1, 4'd15, 32'hFFFFFFFF, 4'hF);
    rd(4'd9, d);
    check("ro_reg9", {96'd0, d}, 128'd0);
    rd(4'd12, d);
    check("rsvd_reg12", {96'd0, d}, 128'd0);
    rd(4'd15, d);
    check("ro_status", {96'd0, d}, 128'd0);

    // 2: normal decrypt run
    for (int i = 0; i < 4; i++) begin
      wr(1'b1, 4'(i), c_KEY[127-32*i -: 32], 4'hF);
      wr(1'b1, 4'(i + 4), c_ENC[127-32*i -: 32], 4'hF);
    end
    rd(4'd0, d);
    check("key_reg0", {96'd0, d}, {96'd0, 32'h00010203});
    check("key_export", {96'd0, EXPORT_DATA}, {96'd0, 32'h00010e0f});
    wr(1'b1, 4'd14, 32'h1, 4'hF);
    check("run_aes_start", {127'd0, AES_START}, 128'd1);
    check("run_aes_key", AES_KEY, c_KEY);
    check("run_aes_enc", AES_MSG_ENC, c_ENC);
    rd(4'd15, d);
    check("run_status_busy", {96'd0, d}, 128'h4);
    AES_DONE    = 1'b1;
    AES_MSG_DEC = c_DEC;
    @(negedge CLK);
    AES_DONE = 1'b0;
    check("hold_aes_start", {127'd0, AES_START}, 128'd1);
    rd(4'd15, d);
    check("hold_status", {96'd0, d}, 128'h1);
    for (int a = 8; a < 12; a++) begin
      rd(4'(a), d);
      check($sformatf("dec_reg%0d", a), {96'd0, d}, {96'd0, 32'hece298dc});
    end
    wr(1'b1, 4'd14, 32'h0, 4'hF);
    check("idle_aes_start", {127'd0, AES_START}, 128'd0);
    rd(4'd15, d);
    check("idle_status_done", {96'd0, d}, 128'h1);

    // 4: core inputs and results locked during RUN
    wr(1'b1, 4'd14, 32'h1, 4'hF);
    wr(1'b1, 4'd0, 32'hFFFFFFFF, 4'hF);
    wr(1'b1, 4'd8, 32'hFFFFFFFF, 4'hF);
    check("lock_aes_key", AES_KEY, c_KEY);
    rd(4'd0, d);
    check("lock_reg0", {96'd0, d}, {96'd0, 32'h00010203});
    rd(4'd8, d);
    check("lock_reg8", {96'd0, d}, {96'd0, 32'hece298dc});
    rd(4'd15, d);
    check("run2_status", {96'd0, d}, 128'h4);
    AES_DONE    = 1'b1;
    AES_MSG_DEC = c_DEC2;
    @(negedge CLK);
    AES_DONE = 1'b0;
    check("lock_aes_key_end", AES_KEY, c_KEY);
    rd(4'd8, d);
    check("dec2_reg8", {96'd0, d}, {96'd0, 32'h01234567});
    rd(4'd11, d);
    check("dec2_reg11", {96'd0, d}, {96'd0, 32'h44556677});
    wr(1'b1, 4'd14, 32'h0, 4'hF);

    // 5: silent core trips the 16-cycle watchdog
    AES_MSG_DEC = '1;
    wr(1'b1, 4'd14, 32'h1, 4'hF);
    repeat (15) @(negedge CLK);
    check("wdog_last_run", {127'd0, AES_START}, 128'd1);
    @(negedge CLK);
    check("abort_aes_start", {127'd0, AES_START}, 128'd0);
    rd(4'd15, d);
    check("abort_status", {96'd0, d}, 128'h2);
    rd(4'd8, d);
    check("abort_reg8", {96'd0, d}, {96'd0, 32'h01234567});
    wr(1'b1, 4'd14, 32'h0, 4'hF);
    check("abort_idle_start", {127'd0, AES_START}, 128'd0);
    rd(4'd15, d);
    check("abort_idle_status", {96'd0, d}, 128'h2);
    wr(1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
    rd(4'd3, d);
    check("idle_wr_reg3", {96'd0, d}, {96'd0, 32'hDEADBEEF});
    check("idle_export", {96'd0, EXPORT_DATA}, {96'd0, 32'h0001BEEF});

    // 6: async reset in the middle of a run
    wr(1'b1, 4'd14, 32'h1, 4'hF);
    repeat (5) @(negedge CLK);
    check("pre_rst_start", {127'd0, AES_START}, 128'd1);
    #5 RESET = 1'b1;
    #1;
    check("async_rst_start", {127'd0, AES_START}, 128'd0);
    check("async_rst_export", {96'd0, EXPORT_DATA}, 128'd0);
    @(negedge CLK);
    RESET = 1'b0;
    check("post_rst_readdata", {96'd0, AVL_READDATA}, 128'd0);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), d);
      check($sformatf("post_rst_reg%0d", a), {96'd0, d}, 128'd0);
    end
    check("post_rst_start", {127'd0, AES_START}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
